// File: rtl/mem_issue_queue_pkg.sv
// Shared sizing, operation encodings, entry layout and the wakeup snoop
// function for the memory issue queue.
package mem_issue_queue_pkg;

  localparam int DEPTH         = 8;
  localparam int TAG_WD        = 6;
  localparam int NUM_WB        = 2;
  localparam int MEM_OP_WD     = 12;
  localparam int INST_STATE_WD = 32;
  localparam int DATA_WD       = 32;
  localparam int PTR_WD        = $clog2(DEPTH);
  localparam int CNT_WD        = PTR_WD + 1;

  // One-hot memory op encoding: {4'b0, lb, lbu, lh, lhu, lw, sb, sh, sw}
  localparam logic [MEM_OP_WD-1:0] OP_SW  = 12'h001;
  localparam logic [MEM_OP_WD-1:0] OP_SH  = 12'h002;
  localparam logic [MEM_OP_WD-1:0] OP_SB  = 12'h004;
  localparam logic [MEM_OP_WD-1:0] OP_LW  = 12'h008;
  localparam logic [MEM_OP_WD-1:0] OP_LHU = 12'h010;
  localparam logic [MEM_OP_WD-1:0] OP_LH  = 12'h020;
  localparam logic [MEM_OP_WD-1:0] OP_LBU = 12'h040;
  localparam logic [MEM_OP_WD-1:0] OP_LB  = 12'h080;

  typedef struct packed {
    logic               rdy;
    logic [TAG_WD-1:0]  tag;
    logic [DATA_WD-1:0] data;
  } src_t;

  typedef struct packed {
    logic [MEM_OP_WD-1:0]     op;
    logic [INST_STATE_WD-1:0] inst_status;
    src_t                     src1;
    src_t                     src2;
  } entry_t;

  // Returns the source after snooping the writeback broadcast. A source that
  // is already ready is left alone; with several matching ports the lowest
  // port index wins, so the loop runs downwards and the last hit sticks.
  function automatic src_t wakeup(input src_t                      src,
                                  input logic [NUM_WB-1:0]         wb_valid,
                                  input logic [NUM_WB*TAG_WD-1:0]  wb_tag,
                                  input logic [NUM_WB*DATA_WD-1:0] wb_data);
    src_t res;
    res = src;
    if (!src.rdy) begin
      for (int i = NUM_WB - 1; i >= 0; i--) begin
        if (wb_valid[i] && (wb_tag[i*TAG_WD +: TAG_WD] == src.tag)) begin
          res.rdy  = 1'b1;
          res.data = wb_data[i*DATA_WD +: DATA_WD];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_issue_queue_if.sv
// Dispatch, wakeup-broadcast and issue signals of the memory issue queue.
// The queue connects through the slave modport; the driving side uses master.
interface mem_issue_queue_if;
  import mem_issue_queue_pkg::*;

  logic                       flush;
  logic                       disp_valid;
  logic                       disp_ready;
  logic [MEM_OP_WD-1:0]       disp_op;
  logic [INST_STATE_WD-1:0]   disp_inst_status;
  logic                       disp_src1_rdy;
  logic [TAG_WD-1:0]          disp_src1_tag;
  logic [DATA_WD-1:0]         disp_src1_data;
  logic                       disp_src2_rdy;
  logic [TAG_WD-1:0]          disp_src2_tag;
  logic [DATA_WD-1:0]         disp_src2_data;
  logic [NUM_WB-1:0]          wb_valid;
  logic [NUM_WB*TAG_WD-1:0]   wb_tag;
  logic [NUM_WB*DATA_WD-1:0]  wb_data;
  logic                       mem_busy;
  logic                       ready;
  logic [MEM_OP_WD-1:0]       op;
  logic [INST_STATE_WD-1:0]   inst_status;
  logic [DATA_WD-1:0]         rdata1;
  logic [DATA_WD-1:0]         rdata2;
  logic [CNT_WD-1:0]          count;

  modport slave (
    input  flush, disp_valid, disp_op, disp_inst_status,
           disp_src1_rdy, disp_src1_tag, disp_src1_data,
           disp_src2_rdy, disp_src2_tag, disp_src2_data,
           wb_valid, wb_tag, wb_data, mem_busy,
    output disp_ready, ready, op, inst_status, rdata1, rdata2, count
  );

  modport master (
    output flush, disp_valid, disp_op, disp_inst_status,
           disp_src1_rdy, disp_src1_tag, disp_src1_data,
           disp_src2_rdy, disp_src2_tag, disp_src2_data,
           wb_valid, wb_tag, wb_data, mem_busy,
    input  disp_ready, ready, op, inst_status, rdata1, rdata2, count
  );
endinterface

// File: rtl/mem_iq_entry.sv
// One issue-queue slot: holds a dispatched memory op and keeps snooping the
// writeback broadcast until both of its source operands are captured.
module mem_iq_entry
  import mem_issue_queue_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       load,
  input  logic                       issue,
  input  entry_t                     load_data,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*TAG_WD-1:0]   wb_tag,
  input  logic [NUM_WB*DATA_WD-1:0]  wb_data,
  output logic                       valid,
  output logic                       rdy,
  output logic [MEM_OP_WD-1:0]       op,
  output logic [INST_STATE_WD-1:0]   inst_status,
  output logic [DATA_WD-1:0]         data1,
  output logic [DATA_WD-1:0]         data2
);

  entry_t q;

  // Slot state: reset/flush empty it, dispatch fills it, otherwise it snoops
  // wakeups and drops its valid bit when it is issued.
  // NOTE: state is updated with non-blocking assignments so every slot and the
  // pointers in the parent all see the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the payload is cleared on reset as well as the valid bit, so a
      // reset leaves no stale operands behind; a flush only clears valid.
      valid <= 1'b0;
      q     <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= load_data;
    end else begin
      if (issue) valid <= 1'b0;
      q.src1 <= wakeup(q.src1, wb_valid, wb_tag, wb_data);
      q.src2 <= wakeup(q.src2, wb_valid, wb_tag, wb_data);
    end
  end

  // Readiness comes from the registered flags only: a wakeup seen this cycle
  // makes the slot issuable on the next one.
  assign rdy         = q.src1.rdy & q.src2.rdy;
  assign op          = q.op;
  assign inst_status = q.inst_status;
  assign data1       = q.src1.data;
  assign data2       = q.src2.data;

endmodule

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue. Ops are dispatched at the tail, wait for
// their operands via writeback wakeup, and only the head may issue, one per
// cycle, as a single-cycle ready pulse to the AGU.
module mem_issue_queue
  import mem_issue_queue_pkg::*;
(
  input logic             clk,
  input logic             reset,
  mem_issue_queue_if.slave bus
);

  logic [PTR_WD:0]   head_q, tail_q;
  logic [CNT_WD-1:0] count_q;
  logic [PTR_WD-1:0] head_idx, tail_idx;
  logic              disp_ready;
  logic              disp_fire;
  logic              issue_fire;
  entry_t            disp_entry;

  logic [DEPTH-1:0]         ent_valid;
  logic [DEPTH-1:0]         ent_rdy;
  logic [MEM_OP_WD-1:0]     ent_op     [DEPTH];
  logic [INST_STATE_WD-1:0] ent_status [DEPTH];
  logic [DATA_WD-1:0]       ent_data1  [DEPTH];
  logic [DATA_WD-1:0]       ent_data2  [DEPTH];

  assign head_idx = head_q[PTR_WD-1:0];
  assign tail_idx = tail_q[PTR_WD-1:0];

  // A full queue refuses dispatch even if the head issues this cycle.
  assign disp_ready = (count_q != CNT_WD'(DEPTH));
  assign disp_fire  = bus.disp_valid & disp_ready & ~bus.flush;
  assign issue_fire = ent_valid[head_idx] & ent_rdy[head_idx] & ~bus.mem_busy & ~bus.flush;

  // Dispatch payload, with any same-cycle broadcast folded in so the wakeup
  // is not lost while the op is being written.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    disp_entry             = '0;
    disp_entry.op          = bus.disp_op;
    disp_entry.inst_status = bus.disp_inst_status;
    disp_entry.src1 = wakeup(src_t'{rdy: bus.disp_src1_rdy, tag: bus.disp_src1_tag,
                                    data: bus.disp_src1_data},
                             bus.wb_valid, bus.wb_tag, bus.wb_data);
    disp_entry.src2 = wakeup(src_t'{rdy: bus.disp_src2_rdy, tag: bus.disp_src2_tag,
                                    data: bus.disp_src2_data},
                             bus.wb_valid, bus.wb_tag, bus.wb_data);
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    mem_iq_entry u_entry (
      .clk         (clk),
      .reset       (reset),
      .flush       (bus.flush),
      .load        (disp_fire  && (tail_idx == PTR_WD'(g))),
      .issue       (issue_fire && (head_idx == PTR_WD'(g))),
      .load_data   (disp_entry),
      .wb_valid    (bus.wb_valid),
      .wb_tag      (bus.wb_tag),
      .wb_data     (bus.wb_data),
      .valid       (ent_valid[g]),
      .rdy         (ent_rdy[g]),
      .op          (ent_op[g]),
      .inst_status (ent_status[g]),
      .data1       (ent_data1[g]),
      .data2       (ent_data2[g])
    );
  end

  // Issue mux: head payload while issuing, all zero otherwise.
  always_comb begin
    bus.ready       = issue_fire;
    bus.op          = '0;
    bus.inst_status = '0;
    bus.rdata1      = '0;
    bus.rdata2      = '0;
    if (issue_fire) begin
      bus.op          = ent_op[head_idx];
      bus.inst_status = ent_status[head_idx];
      bus.rdata1      = ent_data1[head_idx];
      bus.rdata2      = ent_data2[head_idx];
    end
  end

  assign bus.disp_ready = disp_ready;
  assign bus.count      = count_q;

  // Pointers and occupancy; reset and flush both return to an empty queue.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (disp_fire)  tail_q <= tail_q + 1'b1;
      if (issue_fire) head_q <= head_q + 1'b1;
      count_q <= count_q + CNT_WD'(disp_fire) - CNT_WD'(issue_fire);
    end
  end

  // The wrap-bit view of empty/full must agree with the occupancy counter.
  a_empty_matches_count: assert property (@(posedge clk) disable iff (reset)
    (head_q == tail_q) == (count_q == '0));
  a_full_matches_count: assert property (@(posedge clk) disable iff (reset)
    ((head_q[PTR_WD] != tail_q[PTR_WD]) && (head_idx == tail_idx))
      == (count_q == CNT_WD'(DEPTH)));

endmodule

// File: tb/tb_mem_issue_queue.sv
// Bench for mem_issue_queue: directed scenarios followed by random traffic.
// A queue-of-ops reference model predicts each cycle's issue; a separate
// monitor compares the DUT against those predictions.
module tb_mem_issue_queue;
  import mem_issue_queue_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_issue_queue_if bus();

  mem_issue_queue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [MEM_OP_WD-1:0]     op;
    logic [INST_STATE_WD-1:0] st;
    bit                       r1;
    logic [TAG_WD-1:0]        t1;
    logic [DATA_WD-1:0]       d1;
    bit                       r2;
    logic [TAG_WD-1:0]        t2;
    logic [DATA_WD-1:0]       d2;
  } mop_t;

  typedef struct {
    logic [MEM_OP_WD-1:0]     op;
    logic [INST_STATE_WD-1:0] st;
    logic [DATA_WD-1:0]       d1;
    logic [DATA_WD-1:0]       d2;
  } exp_t;

  mop_t mq[$];     // ops held in the queue, oldest first
  exp_t exp_q[$];  // predicted issues awaiting the monitor
  int   exp_cnt;
  bit   exp_rdy;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Resolve one source against the current broadcast: first matching port wins.
  task automatic snoop(input bit rdy_in, input logic [TAG_WD-1:0] tag,
                       input logic [DATA_WD-1:0] din,
                       output bit rdy_out, output logic [DATA_WD-1:0] dout);
    rdy_out = rdy_in;
    dout    = din;
    for (int i = 0; i < NUM_WB; i++) begin
      if (!rdy_out && bus.wb_valid[i] && bus.wb_tag[i*TAG_WD +: TAG_WD] == tag) begin
        rdy_out = 1'b1;
        dout    = bus.wb_data[i*DATA_WD +: DATA_WD];
      end
    end
  endtask

  // Reference model: evaluated mid-cycle once inputs are stable.
  initial forever begin
    @(negedge clk);
    exp_cnt = mq.size();
    exp_rdy = 1'b0;
    if (reset || bus.flush) begin
      mq.delete();
    end else begin
      if (mq.size() != 0 && mq[0].r1 && mq[0].r2 && !bus.mem_busy) begin
        exp_t e;
        e.op = mq[0].op; e.st = mq[0].st; e.d1 = mq[0].d1; e.d2 = mq[0].d2;
        exp_rdy = 1'b1;
        exp_q.push_back(e);
        void'(mq.pop_front());
      end
      if (bus.disp_valid && exp_cnt < DEPTH) begin
        mop_t m;
        m.op = bus.disp_op; m.st = bus.disp_inst_status;
        m.r1 = bus.disp_src1_rdy; m.t1 = bus.disp_src1_tag; m.d1 = bus.disp_src1_data;
        m.r2 = bus.disp_src2_rdy; m.t2 = bus.disp_src2_tag; m.d2 = bus.disp_src2_data;
        mq.push_back(m);
      end
      foreach (mq[k]) begin
        bit r;
        logic [DATA_WD-1:0] d;
        snoop(mq[k].r1, mq[k].t1, mq[k].d1, r, d); mq[k].r1 = r; mq[k].d1 = d;
        snoop(mq[k].r2, mq[k].t2, mq[k].d2, r, d); mq[k].r2 = r; mq[k].d2 = d;
      end
    end
  end

  // Monitor: compares the DUT against the model's prediction for this cycle.
  initial forever begin
    @(negedge clk);
    #1;
    if (!reset) begin
      check("ready", bus.ready, exp_rdy);
      check("count", bus.count, exp_cnt);
      check("disp_ready", bus.disp_ready, exp_cnt != DEPTH);
      if (exp_rdy || bus.ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue", bus.ready, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("op", bus.op, e.op);
          check("inst_status", bus.inst_status, e.st);
          check("rdata1", bus.rdata1, e.d1);
          check("rdata2", bus.rdata2, e.d2);
        end
      end else begin
        check("idle_outputs_zero", |{bus.op, bus.inst_status, bus.rdata1, bus.rdata2}, 1'b0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush      = 1'b0;
    bus.disp_valid = 1'b0;
    bus.wb_valid   = '0;
    bus.mem_busy   = 1'b0;
  endtask

  task automatic set_disp(input logic [MEM_OP_WD-1:0] op,
                          input bit r1, input logic [TAG_WD-1:0] t1, input logic [DATA_WD-1:0] d1,
                          input bit r2, input logic [TAG_WD-1:0] t2, input logic [DATA_WD-1:0] d2);
    bus.disp_valid       = 1'b1;
    bus.disp_op          = op;
    bus.disp_inst_status = $urandom;
    bus.disp_src1_rdy    = r1; bus.disp_src1_tag = t1; bus.disp_src1_data = d1;
    bus.disp_src2_rdy    = r2; bus.disp_src2_tag = t2; bus.disp_src2_data = d2;
  endtask

  task automatic set_wb(input int port, input logic [TAG_WD-1:0] tag, input logic [DATA_WD-1:0] data);
    bus.wb_valid[port]                    = 1'b1;
    bus.wb_tag[port*TAG_WD +: TAG_WD]     = tag;
    bus.wb_data[port*DATA_WD +: DATA_WD]  = data;
  endtask

  task automatic rand_disp();
    int idx;
    idx = $urandom_range(0, 7);
    set_disp(MEM_OP_WD'(1) << idx,
             1'($urandom_range(0, 1)), TAG_WD'($urandom_range(0, 15)), $urandom,
             (idx >= 3) ? 1'b1 : 1'($urandom_range(0, 1)), TAG_WD'($urandom_range(0, 15)), $urandom);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus.wb_tag  = '0;
    bus.wb_data = '0;
    set_disp(OP_LW, 1, 0, 0, 1, 0, 0);
    bus.disp_valid = 1'b0;
    tick(); tick();
    check("reset_ready", bus.ready, 1'b0);
    check("reset_count", bus.count, 0);
    check("reset_disp_ready", bus.disp_ready, 1'b1);
    reset = 1'b0;

    // Ready load issues the cycle after dispatch.
    set_disp(OP_LW, 1, 0, 32'h1000, 1, 0, 0);
    tick(); idle(); #1;
    check("t1_ready", bus.ready, 1'b1);
    check("t1_op", bus.op, OP_LW);
    check("t1_rdata1", bus.rdata1, 32'h1000);
    tick();

    // Store waits on tag 5; issues the cycle after the broadcast.
    set_disp(OP_SW, 1, 0, 32'h2000, 0, 5, 0);
    tick(); idle(); #1;
    check("t2_wait_a", bus.ready, 1'b0);
    tick(); set_wb(0, 5, 32'hDEADBEEF); #1;
    check("t2_wait_b", bus.ready, 1'b0);
    tick(); idle(); #1;
    check("t2_ready", bus.ready, 1'b1);
    check("t2_rdata2", bus.rdata2, 32'hDEADBEEF);
    tick();

    // Head blocked on tag 7 holds back a fully ready younger load.
    set_disp(OP_LB, 0, 7, 0, 1, 0, 0);
    tick();
    set_disp(OP_LW, 1, 0, 32'h55, 1, 0, 0);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      #1; check("t3_blocked", bus.ready, 1'b0);
      tick();
    end
    set_wb(1, 7, 32'h3000);
    tick(); idle(); #1;
    check("t3_head_first", bus.op, OP_LB);
    tick(); tick();

    // Fill the queue while memory is busy; the ninth dispatch is dropped.
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_disp(OP_LW, 1, 0, 32'h100 + i, 1, 0, 0);
      tick();
    end
    idle(); bus.mem_busy = 1'b1; #1;
    check("t4_full_disp_ready", bus.disp_ready, 1'b0);
    check("t4_full_count", bus.count, DEPTH);
    bus.mem_busy = 1'b0;
    repeat (10) tick();
    check("t4_drained", bus.count, 0);

    // Dispatch bypass: wakeup in the dispatch cycle is not lost.
    set_disp(OP_LH, 0, 9, 0, 1, 0, 0);
    set_wb(0, 9, 32'h44);
    tick(); idle(); #1;
    check("t5_ready", bus.ready, 1'b1);
    check("t5_rdata1", bus.rdata1, 32'h44);
    tick();

    // Flush with a concurrent dispatch empties the queue.
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_disp(OP_SB, 1, 0, i, 1, 0, i);
      tick();
    end
    bus.flush = 1'b1;
    set_disp(OP_LW, 1, 0, 32'h77, 1, 0, 0);
    tick(); idle(); #1;
    check("t6_count", bus.count, 0);
    check("t6_disp_ready", bus.disp_ready, 1'b1);
    check("t6_ready", bus.ready, 1'b0);
    tick();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(0, 9) < 6) rand_disp();
      for (int p = 0; p < NUM_WB; p++)
        if ($urandom_range(0, 1) == 1) set_wb(p, TAG_WD'($urandom_range(0, 15)), $urandom);
      bus.mem_busy = ($urandom_range(0, 3) == 0);
      bus.flush    = ($urandom_range(0, 49) == 0);
      tick();
    end

    // Drain: broadcast every tag until the model is empty (bounded).
    idle();
    for (int c = 0; c < 300 && mq.size() != 0; c++) begin
      set_wb(0, TAG_WD'(c % 16), $urandom);
      set_wb(1, TAG_WD'((c + 8) % 16), $urandom);
      tick();
      idle();
    end
    tick(); tick();
    check("drain_count", bus.count, 0);
    check("scoreboard_leftover", exp_q.size(), 0);

    // Reset in the middle of operation.
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_disp(OP_SH, 1, 0, i, 1, 0, i);
      tick();
    end
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("midreset_count", bus.count, 0);
    check("midreset_ready", bus.ready, 1'b0);
    check("midreset_disp_ready", bus.disp_ready, 1'b1);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
